// File: rtl/chacha20_pkg.sv
// Constants and FSM encoding shared by the ChaCha20 datapath blocks.
package chacha20_pkg;

  localparam int WORD_W = 32;

  // Same encoding as the encryptor's control FSM.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RECV = 2'b01,
    HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/chacha20_sync_fifo.sv
// Single-clock word FIFO with a separate occupancy counter, registered pop port and flush.
module chacha20_sync_fifo #(
  parameter  int DEPTH  = 16,
  parameter  int WORD_W = 32,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [WORD_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic [AW:0]       level_o
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       level_q;
  logic [WORD_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              do_wr, do_rd;

  assign do_wr = wr_en_i && !flush_i && (level_q != FULL_LVL);
  assign do_rd = rd_en_i && !flush_i && (level_q != '0);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (flush_i) begin
      // rd_data is deliberately kept across a flush.
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= do_rd;
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        rd_data_q <= mem[rd_ptr_q];
      end
      if (do_wr && !do_rd)      level_q <= level_q + (AW+1)'(1);
      else if (do_rd && !do_wr) level_q <= level_q - (AW+1)'(1);
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign level_o    = level_q;

endmodule

// File: rtl/chacha20_ct_sink.sv
// Ciphertext sink: frames the encryptor's word stream into messages and buffers it for the host.
module chacha20_ct_sink
  import chacha20_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int LEN_W = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              rd_en,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [AW:0]       level,
  output logic              msg_done,
  output logic [LEN_W-1:0]  msg_len
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] msg_len_q, msg_len_d;
  logic             msg_done_q, msg_done_d;
  logic             run_q;
  logic             accept;

  // run_q keeps s_ready low until the first edge after reset release.
  assign s_ready = run_q && (state_q != HOLD) && (level != FULL_LVL);
  assign accept  = s_valid && s_ready && !clear;

  chacha20_sync_fifo #(.DEPTH(DEPTH), .WORD_W(WORD_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (clear),
    .wr_en_i   (accept),
    .wr_data_i (s_data),
    .rd_en_i   (rd_en),
    .rd_data_o (rd_data),
    .rd_valid_o(rd_valid),
    .level_o   (level)
  );

  always_comb begin
    state_d    = state_q;
    msg_len_d  = msg_len_q;
    msg_done_d = accept && s_last;
    unique case (state_q)
      IDLE: if (accept) begin
        msg_len_d = LEN_W'(1);
        state_d   = s_last ? HOLD : RECV;
      end
      RECV: if (accept) begin
        if (msg_len_q != '1) msg_len_d = msg_len_q + LEN_W'(1);
        if (s_last) state_d = HOLD;
      end
      HOLD: if (level == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d    = IDLE;
      msg_len_d  = '0;
      msg_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      msg_len_q  <= '0;
      msg_done_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      msg_len_q  <= msg_len_d;
      msg_done_q <= msg_done_d;
      run_q      <= 1'b1;
    end
  end

  assign msg_done = msg_done_q;
  assign msg_len  = msg_len_q;

endmodule
